// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel format and fill-engine state encoding.
// vga_mem imports the same package, so both sides agree on the framebuffer layout.
package fb_pkg;

    localparam int FB_RES_X     = 320;
    localparam int FB_RES_Y     = 240;
    localparam int FB_MEM_WIDTH = 8;     // 0b00RRGGBB

    function automatic int fb_addr_width(input int res_x, input int res_y);
        return $clog2(res_x * res_y);
    endfunction

    localparam int FB_ADDR_WIDTH = fb_addr_width(FB_RES_X, FB_RES_Y);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fb_rect_fill.sv
// Solid rectangle fill engine: clips a command to the framebuffer and then
// streams one write per cycle in row-major order.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | clip to framebuffer, load counters, compute first row base
// FILL  | one pixel write per cycle
// DONE  | one-cycle done pulse, no write
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int RES_X      = FB_RES_X,
    parameter int RES_Y      = FB_RES_Y,
    parameter int MEM_WIDTH  = FB_MEM_WIDTH,
    parameter int ADDR_WIDTH = fb_addr_width(RES_X, RES_Y)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [$clog2(RES_X)-1:0]   cmd_x0,
    input  logic [$clog2(RES_Y)-1:0]   cmd_y0,
    input  logic [$clog2(RES_X):0]     cmd_w,
    input  logic [$clog2(RES_Y):0]     cmd_h,
    input  logic [MEM_WIDTH-1:0]       cmd_color,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [MEM_WIDTH-1:0]       din,
    output logic                       wen,
    output logic                       busy,
    output logic                       done
);

    localparam int XW = $clog2(RES_X);
    localparam int YW = $clog2(RES_Y);
    localparam logic [XW+1:0]         RX_EXT   = (XW+2)'(RES_X);
    localparam logic [YW+1:0]         RY_EXT   = (YW+2)'(RES_Y);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(RES_X);

    fill_state_t state, state_nxt;

    logic                  ready_en;
    logic [XW-1:0]         x0_q, x_cur;
    logic [YW-1:0]         y0_q;
    logic [XW:0]           w_q, x_cnt, x_reload;
    logic [YW:0]           h_q, y_cnt;
    logic [MEM_WIDTH-1:0]  color_q;
    logic [ADDR_WIDTH-1:0] row_base;

    logic [XW+1:0] room_x, eff_w;
    logic [YW+1:0] room_y, eff_h;
    logic          cmd_empty, accept, row_end, last_pix;

    // room_x/room_y wrap when the origin is off-screen; cmd_empty masks that case
    always_comb begin
        room_x    = RX_EXT - {2'b00, x0_q};
        room_y    = RY_EXT - {2'b00, y0_q};
        eff_w     = ({1'b0, w_q} < room_x) ? {1'b0, w_q} : room_x;
        eff_h     = ({1'b0, h_q} < room_y) ? {1'b0, h_q} : room_y;
        cmd_empty = ({2'b00, x0_q} >= RX_EXT) || ({2'b00, y0_q} >= RY_EXT) ||
                    (eff_w == '0) || (eff_h == '0);
    end

    assign accept   = cmd_valid && cmd_ready;
    assign row_end  = (x_cnt == '0);
    assign last_pix = row_end && (y_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // keeps cmd_ready low while reset is held, even though the state reads IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = cmd_empty ? DONE : FILL;
            FILL:    if (last_pix) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = ready_en && (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign wen       = (state == FILL);
    assign mem_addr  = wen ? (row_base + ADDR_WIDTH'(x_cur)) : '0;
    assign din       = wen ? color_q : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            color_q  <= '0;
            x_cur    <= '0;
            x_cnt    <= '0;
            x_reload <= '0;
            y_cnt    <= '0;
            row_base <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x0_q    <= cmd_x0;
                        y0_q    <= cmd_y0;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                    end
                end
                SETUP: begin
                    x_cur    <= x0_q;
                    x_cnt    <= eff_w[XW:0] - (XW+1)'(1);
                    x_reload <= eff_w[XW:0] - (XW+1)'(1);
                    y_cnt    <= eff_h[YW:0] - (YW+1)'(1);
                    row_base <= ADDR_WIDTH'(y0_q) * ROW_STEP;
                end
                FILL: begin
                    // row stepping is a running add, so no per-pixel multiply
                    if (row_end) begin
                        x_cnt    <= x_reload;
                        x_cur    <= x0_q;
                        y_cnt    <= y_cnt - (YW+1)'(1);
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        x_cnt <= x_cnt - (XW+1)'(1);
                        x_cur <= x_cur + XW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
